// File: rtl/multi_pkg.sv
// multi_pkg: shared constants, FSM state type and helper function for the
// time-multiplexed 78x78 partial-product scheduler (multi_sched).
//   A_W/B_W   : chunk widths of the a and b operands (26 and 17 bits)
//   P_W       : width of one chunk product (26 + 17 = 43 bits)
//   NUM_A/B   : number of a and b chunks; NUM_PP = NUM_A * NUM_B products
//   TAG_W     : width of the slot tag that travels with each lane pipeline
package multi_pkg;

    localparam int A_W    = 26;
    localparam int B_W    = 17;
    localparam int P_W    = 43;
    localparam int NUM_A  = 3;
    localparam int NUM_B  = 5;
    localparam int NUM_PP = 15;
    localparam int TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Number of issue groups needed to cover all products with num_mul lanes.
    function automatic int num_groups(input int num_mul);
        return (NUM_PP + num_mul - 1) / num_mul;
    endfunction

endpackage

// File: rtl/mul_lane.sv
// mul_lane: one shared multiplier lane. Registered unsigned 26x17 -> 43-bit
// multiplier with MUL_LAT pipeline stages, plus a parallel valid bit and slot
// tag pipeline so the result can be steered to its product slot on exit.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_tag     : issue strobe and destination slot for this cycle
//   in_a, in_b          : 26-bit and 17-bit operand chunks
//   out_valid/out_tag   : product leaving the final stage and its slot
//   out_p               : exact 43-bit product
//   pending             : a valid product is still in a non-final stage
module mul_lane
    import multi_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [P_W-1:0]   out_p,
    output logic             pending
);

    logic [P_W-1:0]   p_q   [MUL_LAT];
    logic [P_W-1:0]   p_d   [MUL_LAT];
    logic [TAG_W-1:0] tag_q [MUL_LAT];
    logic [TAG_W-1:0] tag_d [MUL_LAT];
    logic [MUL_LAT-1:0] v_q;
    logic [MUL_LAT-1:0] v_d;

    // Stage 0 captures the product; later stages just shift it along.
    always_comb begin
        p_d[0]   = P_W'(in_a) * P_W'(in_b);
        tag_d[0] = in_tag;
        v_d      = '0;
        v_d[0]   = in_valid;
        for (int s = 1; s < MUL_LAT; s++) begin
            p_d[s]   = p_q[s-1];
            tag_d[s] = tag_q[s-1];
            v_d[s]   = v_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                p_q[s]   <= '0;
                tag_q[s] <= '0;
            end
            v_q <= '0;
        end else begin
            p_q   <= p_d;
            tag_q <= tag_d;
            v_q   <= v_d;
        end
    end

    // The final stage is being captured this cycle, so only earlier stages
    // count as still in flight.
    always_comb begin
        pending = 1'b0;
        for (int s = 0; s < MUL_LAT - 1; s++) begin
            pending = pending | v_q[s];
        end
    end

    assign out_valid = v_q[MUL_LAT-1];
    assign out_tag   = tag_q[MUL_LAT-1];
    assign out_p     = p_q[MUL_LAT-1];

endmodule

// File: rtl/multi_sched.sv
// multi_sched: time-multiplexed scheduler for the 78x78 partial-product
// multiplier. Splits a into 3x26-bit chunks and b into 5x17-bit chunks (the
// top b chunk is b[77:68] zero-extended), issues the 15 chunk products over
// NUM_MUL shared mul_lane instances, and presents all products at once.
// Optional feature macro: MULTI_SCHED_PERF_EN adds job_cnt and busy_cyc.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready, a, b : operand handshake (accepted only in IDLE)
//   out_valid/out_ready     : product handshake (held in DONE)
//   res_flat                : product k = a_chunk[k/5] * b_chunk[k%5] at k*43
//   busy                    : FSM not in IDLE
//   job_cnt, busy_cyc       : (perf only) completed jobs, non-idle cycles
module multi_sched
    import multi_pkg::*;
#(
    parameter int RADIX   = 78,
    parameter int NUM_MUL = 3,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RADIX-1:0]        a,
    input  logic [RADIX-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_PP*P_W-1:0]   res_flat,
    output logic                    busy
`ifdef MULTI_SCHED_PERF_EN
    ,
    output logic [31:0]             job_cnt,
    output logic [31:0]             busy_cyc
`endif
);

    localparam int G = num_groups(NUM_MUL);

    state_t           state_q, state_d;
    logic [3:0]       grp_q, grp_d;
    logic [RADIX-1:0] a_q, a_d, b_q, b_d;
    logic [P_W-1:0]   res_q [NUM_PP];
    logic [P_W-1:0]   res_d [NUM_PP];

    logic [A_W-1:0]   a_chunk [NUM_A];
    logic [B_W-1:0]   b_chunk [NUM_B];

    logic             lane_iv   [NUM_MUL];
    logic [TAG_W-1:0] lane_itag [NUM_MUL];
    logic [A_W-1:0]   lane_ia   [NUM_MUL];
    logic [B_W-1:0]   lane_ib   [NUM_MUL];
    logic             lane_ov   [NUM_MUL];
    logic [TAG_W-1:0] lane_otag [NUM_MUL];
    logic [P_W-1:0]   lane_op   [NUM_MUL];
    logic             lane_pend [NUM_MUL];
    logic             any_pend;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_comb begin
        for (int i = 0; i < NUM_A; i++) begin
            a_chunk[i] = a_q[i*A_W +: A_W];
        end
        for (int j = 0; j < NUM_B - 1; j++) begin
            b_chunk[j] = b_q[j*B_W +: B_W];
        end
        b_chunk[NUM_B-1] = B_W'(b_q[RADIX-1:(NUM_B-1)*B_W]);
    end

    // Lane L of group g handles slot g*NUM_MUL+L; slots past the last product
    // (only possible in the final group) are issued as bubbles.
    always_comb begin
        for (int l = 0; l < NUM_MUL; l++) begin
            int k;
            k            = int'(grp_q) * NUM_MUL + l;
            lane_iv[l]   = (state_q == ISSUE) && (k < NUM_PP);
            lane_itag[l] = TAG_W'(k);
            lane_ia[l]   = '0;
            lane_ib[l]   = '0;
            if (k < NUM_PP) begin
                lane_ia[l] = a_chunk[2'(k / NUM_B)];
                lane_ib[l] = b_chunk[3'(k % NUM_B)];
            end
        end
    end

    for (genvar l = 0; l < NUM_MUL; l++) begin : g_lane
        mul_lane #(.MUL_LAT(MUL_LAT)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (lane_iv[l]),
            .in_tag    (lane_itag[l]),
            .in_a      (lane_ia[l]),
            .in_b      (lane_ib[l]),
            .out_valid (lane_ov[l]),
            .out_tag   (lane_otag[l]),
            .out_p     (lane_op[l]),
            .pending   (lane_pend[l])
        );
    end

    always_comb begin
        any_pend = 1'b0;
        for (int l = 0; l < NUM_MUL; l++) begin
            any_pend = any_pend | lane_pend[l];
        end
    end

    // DRAIN leaves on the same edge that captures the last product, which
    // makes out_valid rise exactly G+MUL_LAT edges after the accept.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    grp_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (grp_q == 4'(G - 1)) begin
                    state_d = DRAIN;
                end else begin
                    grp_d = grp_q + 4'd1;
                end
            end
            DRAIN: begin
                if (!any_pend) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_d = res_q;
        for (int l = 0; l < NUM_MUL; l++) begin
            if (lane_ov[l] && (lane_otag[l] < 4'(NUM_PP))) begin
                res_d[lane_otag[l]] = lane_op[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int k = 0; k < NUM_PP; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        res_flat = '0;
        for (int k = 0; k < NUM_PP; k++) begin
            res_flat[k*P_W +: P_W] = res_q[k];
        end
    end

`ifdef MULTI_SCHED_PERF_EN
    logic [31:0] job_cnt_q, job_cnt_d;
    logic [31:0] busy_cyc_q, busy_cyc_d;

    always_comb begin
        job_cnt_d  = job_cnt_q;
        busy_cyc_d = busy_cyc_q;
        if (out_valid && out_ready) begin
            job_cnt_d = job_cnt_q + 32'd1;
        end
        if (busy) begin
            busy_cyc_d = busy_cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cnt_q  <= '0;
            busy_cyc_q <= '0;
        end else begin
            job_cnt_q  <= job_cnt_d;
            busy_cyc_q <= busy_cyc_d;
        end
    end

    assign job_cnt  = job_cnt_q;
    assign busy_cyc = busy_cyc_q;
`endif

endmodule

// File: tb/tb_multi_sched.sv
// tb_multi_sched: directed bench for multi_sched. Three instances share clock,
// reset and operands: dut0 at defaults (NUM_MUL=3, MUL_LAT=2), dut1 with
// NUM_MUL=15/MUL_LAT=1 and dut2 with NUM_MUL=4/MUL_LAT=3.
module tb_multi_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [77:0] a;
    logic [77:0] b;

    logic         in_valid_v  [3];
    logic         out_ready_v [3];
    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic         busy_v      [3];
    logic [644:0] res_v       [3];
`ifdef MULTI_SCHED_PERF_EN
    logic [31:0]  job_cnt_v   [3];
    logic [31:0]  busy_cyc_v  [3];
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [42:0] ONES_LO = 43'h7FFFBFE0001;
    localparam logic [42:0] ONES_HI = 43'h000FFBFFFC01;

    always #5 clk = ~clk;

    multi_sched #(.RADIX(78), .NUM_MUL(3), .MUL_LAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .res_flat(res_v[0]), .busy(busy_v[0])
`ifdef MULTI_SCHED_PERF_EN
        , .job_cnt(job_cnt_v[0]), .busy_cyc(busy_cyc_v[0])
`endif
    );

    multi_sched #(.RADIX(78), .NUM_MUL(15), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .res_flat(res_v[1]), .busy(busy_v[1])
`ifdef MULTI_SCHED_PERF_EN
        , .job_cnt(job_cnt_v[1]), .busy_cyc(busy_cyc_v[1])
`endif
    );

    multi_sched #(.RADIX(78), .NUM_MUL(4), .MUL_LAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .res_flat(res_v[2]), .busy(busy_v[2])
`ifdef MULTI_SCHED_PERF_EN
        , .job_cnt(job_cnt_v[2]), .busy_cyc(busy_cyc_v[2])
`endif
    );

    // Reference chunk product k = a_chunk[k/5] * b_chunk[k%5].
    function automatic logic [42:0] ref_pp(input logic [77:0] av, input logic [77:0] bv, input int k);
        int i;
        int j;
        logic [25:0] ac;
        logic [16:0] bc;
        i  = k / 5;
        j  = k % 5;
        ac = av[i*26 +: 26];
        if (j < 4) bc = bv[j*17 +: 17];
        else       bc = {7'b0, bv[77:68]};
        return 43'(ac) * 43'(bc);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand pair to dut d and returns the number of rising
    // edges after the accept edge until out_valid is seen (bounded).
    task automatic applyStimulus(input int d, input logic [77:0] av, input logic [77:0] bv, output int lat);
        @(negedge clk);
        checkOutput("in_ready_idle", 64'(in_ready_v[d]), 64'd1);
        a = av;
        b = bv;
        in_valid_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        lat = 0;
        while (out_valid_v[d] !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finishJob(input int d);
        @(negedge clk);
        out_ready_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_v[d] = 1'b0;
        checkOutput("in_ready_after_hs", 64'(in_ready_v[d]), 64'd1);
        checkOutput("out_valid_after_hs", 64'(out_valid_v[d]), 64'd0);
    endtask

    task automatic checkRef(input int d, input logic [77:0] av, input logic [77:0] bv, input string tag);
        for (int k = 0; k < 15; k++) begin
            checkOutput($sformatf("%s_res%0d", tag, k), 64'(res_v[d][k*43 +: 43]), 64'(ref_pp(av, bv, k)));
        end
    endtask

    initial begin
        int          lat;
        int          seen;
        logic        stable_ok;
        logic [644:0] snap;
        logic [95:0] ra;
        logic [95:0] rb;

        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        for (int d = 0; d < 3; d++) begin
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        checkOutput("rst_busy", 64'(busy_v[0]), 64'd0);
        checkOutput("rst_res_zero", 64'(res_v[0] == '0), 64'd1);
        rst_n = 1'b1;

        // All-ones operands.
        applyStimulus(0, {78{1'b1}}, {78{1'b1}}, lat);
        checkOutput("ones_latency", 64'(lat), 64'd7);
        checkOutput("ones_busy", 64'(busy_v[0]), 64'd1);
        for (int k = 0; k < 15; k++) begin
            checkOutput($sformatf("ones_res%0d", k), 64'(res_v[0][k*43 +: 43]),
                        64'((k % 5 == 4) ? ONES_HI : ONES_LO));
        end
        finishJob(0);
        checkOutput("idle_busy", 64'(busy_v[0]), 64'd0);

        // a=1, b=1, then hold out_ready low with a stray in_valid present.
        applyStimulus(0, 78'd1, 78'd1, lat);
        checkOutput("one_latency", 64'(lat), 64'd7);
        for (int k = 0; k < 15; k++) begin
            checkOutput($sformatf("one_res%0d", k), 64'(res_v[0][k*43 +: 43]), (k == 0) ? 64'd1 : 64'd0);
        end
        snap      = res_v[0];
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid_v[0] = 1'b1;
            a = {78{1'b1}};
            b = {78{1'b1}};
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || res_v[0] !== snap) stable_ok = 1'b0;
        end
        in_valid_v[0] = 1'b0;
        checkOutput("backpressure_stable", 64'(stable_ok), 64'd1);
        finishJob(0);

        // Second job: only product 11 is non-zero.
        applyStimulus(0, 78'd1 << 52, 78'd1 << 17, lat);
        checkOutput("job2_latency", 64'(lat), 64'd7);
        for (int k = 0; k < 15; k++) begin
            checkOutput($sformatf("job2_res%0d", k), 64'(res_v[0][k*43 +: 43]), (k == 11) ? 64'd1 : 64'd0);
        end
        finishJob(0);

        // Reset during the third ISSUE cycle.
        @(negedge clk);
        a = {78{1'b1}};
        b = {78{1'b1}};
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 64'(in_ready_v[0]), 64'd1);
        checkOutput("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        checkOutput("abort_busy", 64'(busy_v[0]), 64'd0);
        checkOutput("abort_res_zero", 64'(res_v[0] == '0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_v[0] === 1'b1) seen++;
        end
        checkOutput("abort_no_out_valid", 64'(seen), 64'd0);

        // Three jobs with out_ready held high.
        out_ready_v[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            applyStimulus(0, ra[77:0], rb[77:0], lat);
            checkOutput($sformatf("free_latency%0d", n), 64'(lat), 64'd7);
            if (n == 2) checkRef(0, ra[77:0], rb[77:0], "free");
        end
        @(negedge clk);
        out_ready_v[0] = 1'b0;
`ifdef MULTI_SCHED_PERF_EN
        checkOutput("perf_job_cnt", 64'(job_cnt_v[0]), 64'd3);
        checkOutput("perf_busy_cyc", 64'(busy_cyc_v[0]), 64'd24);
`endif

        // NUM_MUL=15, MUL_LAT=1.
        ra = {$urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom};
        applyStimulus(1, ra[77:0], rb[77:0], lat);
        checkOutput("wide_latency", 64'(lat), 64'd2);
        checkRef(1, ra[77:0], rb[77:0], "wide");
        finishJob(1);

        // NUM_MUL=4, MUL_LAT=3.
        ra = {$urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom};
        applyStimulus(2, ra[77:0], rb[77:0], lat);
        checkOutput("deep_latency", 64'(lat), 64'd7);
        checkRef(2, ra[77:0], rb[77:0], "deep");
        finishJob(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
